spi_seq_ctrl: RTL

SPI_SEQ_CTRL -- requirements
Module: spi_seq_ctrl

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_byte_fifo.sv | 49 ++++
 rtl/spi_seq_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer: FSM encodings and
// parameter defaults used by the top and its byte FIFOs.
package spi_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int CSDLY_DEF = 2;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    CSSETUP = 4'd1,
    LOAD    = 4'd2,
    GO      = 4'd3,
    WAITHI  = 4'd4,
    WAITLO  = 4'd5,
    STORE   = 4'd6,
    CSHOLD  = 4'd7,
    DONE    = 4'd8
  } state_t;

endpackage

// File: rtl/spi_byte_fifo.sv
// First-word-fall-through byte FIFO. Writes when full and reads when empty
// are dropped here; the parent flags them as errors.
module spi_byte_fifo
  import spi_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       full,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  // Gate the head so an empty FIFO presents zero rather than stale storage.
  assign dout  = empty ? 8'h00 : mem[rd_ptr_q];

  always_ff @(posedge clkin) begin
    if (do_wr) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + (AW+1)'(1);
      else if (do_rd && !do_wr) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/spi_seq_ctrl.sv
// SPI command sequencer: moves cmd_len bytes from the TX FIFO through an
// external byte engine into the RX FIFO, framing them with chip select.
module spi_seq_ctrl
  import spi_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CSDLY = CSDLY_DEF
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_len,
  input  logic       cmd_keepcs,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  input  logic       cspol,
  output logic       cs,
  output logic       spi_go,
  output logic [7:0] spi_dout,
  input  logic       spi_state,
  input  logic [7:0] spi_din
);

  localparam logic [3:0] DLY_LOAD = 4'(CSDLY - 1);

  state_t     state_q, state_d;
  logic [8:0] cnt_q;
  logic [3:0] dly_q;
  logic       keepcs_q, cs_act_q, err_q;
  logic [7:0] dout_q, din_q;
  logic       tx_pop, rx_push, tx_empty, rx_full;
  logic [7:0] tx_head;

  spi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clkin(clkin), .rst(rst),
    .wr(tx_wr), .din(tx_data), .full(tx_full),
    .rd(tx_pop), .dout(tx_head), .empty(tx_empty)
  );

  spi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clkin(clkin), .rst(rst),
    .wr(rx_push), .din(din_q), .full(rx_full),
    .rd(rx_rd), .dout(rx_data), .empty(rx_empty)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = cs_act_q ? LOAD : CSSETUP;
      CSSETUP: if (dly_q == 4'd0) state_d = LOAD;
      LOAD:    if (!tx_empty) state_d = GO;
      GO:      state_d = WAITHI;
      WAITHI:  if (spi_state) state_d = WAITLO;
      WAITLO:  if (!spi_state) state_d = STORE;
      STORE: begin
        if (!rx_full) begin
          if (cnt_q != 9'd1) state_d = LOAD;
          else               state_d = keepcs_q ? DONE : CSHOLD;
        end
      end
      CSHOLD:  if (dly_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    spi_go    = (state_q == GO);
    tx_pop    = (state_q == LOAD) && !tx_empty;
    rx_push   = (state_q == STORE) && !rx_full;
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      dly_q    <= '0;
      keepcs_q <= 1'b0;
      cs_act_q <= 1'b0;
      dout_q   <= '0;
      din_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && cmd_valid) begin
        cnt_q    <= (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
        keepcs_q <= cmd_keepcs;
        if (!cs_act_q) cs_act_q <= 1'b1;
      end
      // Both CS timers share one down-counter, loaded on entry.
      if (state_d != state_q && (state_d == CSSETUP || state_d == CSHOLD))
        dly_q <= DLY_LOAD;
      else if ((state_q == CSSETUP || state_q == CSHOLD) && dly_q != 4'd0)
        dly_q <= dly_q - 4'd1;
      if (state_q == CSHOLD && dly_q == 4'd0) cs_act_q <= 1'b0;
      if (tx_pop) dout_q <= tx_head;
      if (state_q == WAITLO && !spi_state) din_q <= spi_din;
      if (rx_push) cnt_q <= cnt_q - 9'd1;
      // A coincident error event wins over the clear.
      if ((tx_wr && tx_full) || (rx_rd && rx_empty)) err_q <= 1'b1;
      else if (err_clr)                              err_q <= 1'b0;
    end
  end

  assign cs       = cs_act_q ? ~cspol : cspol;
  assign spi_dout = dout_q;
  assign err      = err_q;

endmodule
